// File: rtl/psk_tx_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : psk_tx_ctrl_if
// Description : Byte-stream valid/ready handshake feeding the PSK transmit
//               sequencer. The master offers bytes; the slave accepts them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface psk_tx_ctrl_if;
  logic [7:0] in_data;   // byte to transmit, MSB sent first
  logic       in_last;   // final byte of a frame, qualified by in_valid
  logic       in_valid;  // byte offered
  logic       in_ready;  // holding register empty

  modport master (
    output in_data,
    output in_last,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_last,
    input  in_valid,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/psk_tx_ctrl.sv
//------------------------------------------------------------------------------
// Module      : psk_tx_ctrl
// Description : 2PSK transmit sequencer. Frames handshaked bytes as an
//               alternating preamble, MSB-first data and an all-ones tail, and
//               emits one code bit per symbol period plus the matching DDS
//               phase-offset word (bit 1 -> 0 deg, bit 0 -> 180 deg).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psk_tx_ctrl #(
  parameter int SYM_CYCLES    = 64,  // clock cycles per symbol, >= 2
  parameter int PREAMBLE_BITS = 8,   // alternating preamble symbols, >= 1
  parameter int TAIL_BITS     = 2,   // all-ones tail symbols, >= 1
  parameter int PHASE_W       = 10   // DDS phase-offset word width
) (
  input  wire logic               clk,
  input  wire logic               rst,
  psk_tx_ctrl_if.slave            tx_in,
  output logic                    ser_code,
  output logic [PHASE_W-1:0]      phase_offset,
  output logic                    sym_strobe,
  output logic                    busy,
  output logic                    underrun
);

  localparam int CNT_W   = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int SEQ_MAX = (PREAMBLE_BITS > TAIL_BITS) ? PREAMBLE_BITS : TAIL_BITS;
  localparam int IDX_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(SYM_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_CNT_PRE   = CNT_W'(SYM_CYCLES - 2);
  localparam logic [IDX_W-1:0]   c_PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0]   c_TAIL_LAST = IDX_W'(TAIL_BITS - 1);
  localparam logic [PHASE_W-1:0] c_PHASE_180 = PHASE_W'(1) << (PHASE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_TAIL     = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;        // cycle within the current symbol
  logic [IDX_W-1:0]   r_idx;        // symbol index within preamble / tail
  logic [2:0]         r_bit;        // data bit index within the current byte
  logic [7:0]         r_sh;         // data shift register, MSB is on air
  logic               r_sh_last;    // byte in r_sh closes the frame
  logic [7:0]         r_hold;       // one-byte holding register
  logic               r_hold_last;
  logic               r_hold_full;

  logic               w_xfer;
  logic               w_cnt_last;
  logic               w_cnt_pre;
  logic               w_pre_end;
  logic               w_byte_end;
  logic               w_load;
  logic               w_ser_next;
  logic               w_und_next;

  assign tx_in.in_ready = ~r_hold_full;

  assign w_xfer     = tx_in.in_valid & ~r_hold_full;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_cnt_pre  = (r_cnt == c_CNT_PRE);
  assign w_pre_end  = (r_state == S_PREAMBLE) && w_cnt_last && (r_idx == c_PRE_LAST);
  assign w_byte_end = (r_state == S_DATA) && w_cnt_last && (r_bit == 3'd7);
  // Shift register takes the held byte at the end of the preamble and, with
  // no gap, at the end of every byte when a successor is already waiting.
  assign w_load     = w_pre_end | (w_byte_end & r_hold_full);

  // Underrun is a registered pulse that must coincide with the last cycle of
  // bit 7, so it is raised one cycle early. The holding register cannot fill
  // at the boundary edge in time to matter, so its value after this edge is
  // exactly what the boundary decision will see.
  assign w_und_next = (r_state == S_DATA) && (r_bit == 3'd7) && w_cnt_pre &&
                      !r_sh_last && !(r_hold_full | w_xfer);

  // Next code bit; ser_code and phase_offset both register from this value.
  always_comb begin
    w_ser_next = ser_code;
    case (r_state)
      S_IDLE: begin
        w_ser_next = 1'b1;
      end
      S_PREAMBLE: begin
        if (w_cnt_last) begin
          // Symbol k outputs ~k[0]; the next symbol is r_idx+1, whose
          // inverted LSB equals r_idx[0].
          w_ser_next = (r_idx == c_PRE_LAST) ? r_hold[7] : r_idx[0];
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          if (r_bit != 3'd7) begin
            w_ser_next = r_sh[6];
          end else if (r_hold_full) begin
            w_ser_next = r_hold[7];
          end else begin
            w_ser_next = 1'b1;
          end
        end
      end
      S_TAIL: begin
        w_ser_next = 1'b1;
      end
      default: begin
        w_ser_next = 1'b1;
      end
    endcase
  end

  // Holding register: filled by the handshake, emptied by a shift-register load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= 8'h00;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
    end else if (w_xfer) begin
      r_hold      <= tx_in.in_data;
      r_hold_last <= tx_in.in_last;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Frame sequencer with registered serial, phase, strobe, busy and underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_bit        <= 3'd0;
      r_sh         <= 8'h00;
      r_sh_last    <= 1'b0;
      ser_code     <= 1'b1;
      phase_offset <= '0;
      sym_strobe   <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      ser_code     <= w_ser_next;
      phase_offset <= w_ser_next ? '0 : c_PHASE_180;
      underrun     <= w_und_next;
      // The cycle after cnt==SYM_CYCLES-2 is the last cycle of the symbol;
      // a busy state never leaves to IDLE on that edge, so busy holds too.
      sym_strobe   <= (r_state != S_IDLE) && w_cnt_pre;

      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          if (r_hold_full) begin
            r_state <= S_PREAMBLE;
            r_idx   <= '0;
            busy    <= 1'b1;
          end
        end
        S_PREAMBLE: begin
          if (w_cnt_last) begin
            if (r_idx == c_PRE_LAST) begin
              r_state   <= S_DATA;
              r_sh      <= r_hold;
              r_sh_last <= r_hold_last;
              r_bit     <= 3'd0;
              r_idx     <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            if (r_bit != 3'd7) begin
              r_sh  <= r_sh << 1;
              r_bit <= r_bit + 3'd1;
            end else if (r_hold_full) begin
              r_sh      <= r_hold;
              r_sh_last <= r_hold_last;
              r_bit     <= 3'd0;
            end else begin
              // Either the frame closed normally or the source ran dry;
              // both finish with the tail.
              r_state <= S_TAIL;
              r_idx   <= '0;
            end
          end
        end
        S_TAIL: begin
          if (w_cnt_last) begin
            if (r_idx == c_TAIL_LAST) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
              busy    <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/psk_tx_ctrl.md
# psk_tx_ctrl

Transmit sequencer for the 2PSK modulator. Accepts bytes over a valid/ready handshake and frames them as preamble, MSB-first data and tail. Emits one serial code bit per symbol period, plus a matching DDS phase-offset word. Output bit 1 selects the 0° carrier and bit 0 selects the 180° carrier, consistent with the PSK select logic downstream.

## Interface

- `SYM_CYCLES`, 64: clock cycles per symbol, ≥2.
- `PREAMBLE_BITS`, 8: alternating preamble symbols per frame, ≥1, starting with 1.
- `TAIL_BITS`, 2: all-ones symbols appended after the last data bit, ≥1.
- `PHASE_W`, 10: width of the DDS phase-offset word.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 8: byte to transmit.
- `in_last` in 1: marks the final byte of a frame; qualified by `in_valid`.
- `in_valid` in 1: byte offered.
- `in_ready` out 1: holding register empty; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `ser_code` out 1: serial code bit driving the PSK carrier select.
- `phase_offset` out PHASE_W: `0` when `ser_code`=1, `1<<(PHASE_W-1)` (180°) when `ser_code`=0.
- `sym_strobe` out 1: one-cycle pulse on the last cycle of every symbol while not IDLE.
- `busy` out 1: state ≠ IDLE.
- `underrun` out 1: one-cycle pulse when a non-last byte finishes and no next byte is held.

## Operation

**Reset values** (applied at the first edge with `rst`=1):
- `ser_code`=1, `phase_offset`=0.
- `in_ready`=1, `busy`=0, `sym_strobe`=0, `underrun`=0.
- State IDLE; holding register empty; counters 0.
- A reset mid-frame discards the held byte and the shift register. There is no tail.

**Datapath**
- One-byte holding register (`hold`, `hold_last`, `hold_full`); `in_ready` = `!hold_full`.
- 8-bit shift register (`sh`, `sh_last`); bit counter 0..7.
- Symbol counter `cnt` runs 0..SYM_CYCLES-1 and wraps; it is cleared on entry to PREAMBLE.
- The symbol boundary is the edge at which `cnt`=SYM_CYCLES-1.
- `phase_offset` is registered from the same next-state value as `ser_code`, so the two always change on the same edge.

**State machine**
- **IDLE:** `ser_code`=1.
  - If `hold_full`, go to PREAMBLE at the next edge with `cnt`=0 and `ser_code`=1.
- **PREAMBLE:** symbol k (0-based) outputs `ser_code` = ~k[0].
  - At the boundary of symbol PREAMBLE_BITS-1, go to DATA: load `sh`←`hold`, `sh_last`←`hold_last`, clear `hold_full`, output `ser_code`=`hold[7]`.
- **DATA:** each boundary shifts `sh` left and outputs the next bit.
  - At the boundary of bit 7, if `hold_full`: reload from `hold` with no gap.
  - Otherwise, if `sh_last`: go to TAIL.
  - Otherwise: pulse `underrun` on that cycle, then go to TAIL.
- **TAIL:** `ser_code`=1 for TAIL_BITS symbols; the final boundary goes to IDLE.
  - If `hold_full` is already set at that point, IDLE immediately starts a new PREAMBLE on the next edge.

**Handshake during a frame**
- Handshakes are accepted in any state whenever `hold_full`=0.
- A byte accepted during TAIL waits in `hold` and starts a new frame.
- A handshake and a reload never happen in the same cycle, because `in_ready`=0 whenever `hold_full`=1.

## Timing

- A handshake at edge E0 sets `hold_full` after E0.
- At E1 the state is PREAMBLE and the first symbol begins. Latency from handshake to first symbol is 1 cycle.
- Every symbol lasts exactly SYM_CYCLES cycles. `ser_code` changes only at symbol boundaries.
- `in_ready` rises the cycle after each load into `sh`. The next byte must be accepted within 8·SYM_CYCLES−1 cycles, or `underrun` fires.
- Frame duration, handshake to IDLE: 1 + (PREAMBLE_BITS + 8·N + TAIL_BITS)·SYM_CYCLES cycles, for N bytes with no underrun.
- `busy` is high from E1 through the last TAIL cycle.

## Test plan

All scenarios use SYM_CYCLES=4, PREAMBLE_BITS=4, TAIL_BITS=2.

- **Single byte:** byte 0xA5 with `in_last`=1.
  - Required: `ser_code` per 4-cycle symbol = 1,0,1,0 | 1,0,1,0,0,1,0,1 | 1,1.
  - `busy` high for 56 cycles. `phase_offset` is 0x200 exactly when `ser_code`=0. 14 `sym_strobe` pulses.
- **Two bytes:** 0x3C, then 0xFF with `in_last`=1, offered as soon as `in_ready` rises.
  - Required: 16 contiguous data symbols 0,0,1,1,1,1,0,0,1,…,1 and no `underrun`. `busy` high for 88 cycles.
- **Underrun:** 0x0F with `in_last`=0, no further byte.
  - Required: data 0,0,0,0,1,1,1,1, then `underrun` pulses once on the last cycle of bit 7, then 2 tail symbols, then IDLE.
- **Backpressure:** hold `in_valid`=1 continuously across a 3-byte frame.
  - Required: `in_ready` is low from each acceptance until the next load, and exactly 3 transfers occur.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3.
  - Required: at the next edge, `ser_code`=1, `phase_offset`=0, `busy`=0, `in_ready`=1. No tail symbols follow.
- **Back-to-back frames:** second frame's byte accepted during TAIL.
  - Required: after TAIL ends, IDLE for exactly 1 cycle, then a new preamble starting with 1.
